// File: rtl/pipeline_reg_pkg.sv
// pipeline_reg_pkg: shared widths, depth limit and word type for the pipeline delay line.
package pipeline_reg_pkg;
    localparam int PIPE_DEFAULT_WIDTH = 32;
    localparam int PIPE_MAX_DEPTH     = 64;
    typedef logic [PIPE_DEFAULT_WIDTH-1:0] pipe_word_t;
endpackage

// File: rtl/pipeline_stage.sv
// pipeline_stage: one WIDTH-bit register with asynchronous active-low reset to RESET_VAL.
module pipeline_stage
    import pipeline_reg_pkg::*;
#(
    parameter int               WIDTH     = PIPE_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_q <= RESET_VAL;
        else          r_q <= i_d;
    end
    assign o_q = r_q;
endmodule

// File: rtl/pipeline_reg.sv
// pipeline_reg: fixed-latency delay line of DEPTH register stages; DEPTH=0 is a plain wire.
module pipeline_reg
    import pipeline_reg_pkg::*;
#(
    parameter int               DEPTH     = 1,
    parameter int               WIDTH     = PIPE_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);
    if (DEPTH < 0 || DEPTH > PIPE_MAX_DEPTH || WIDTH < 1) begin : g_bad_params
        $error("pipeline_reg: DEPTH=%0d must be 0..%0d and WIDTH=%0d must be >= 1",
               DEPTH, PIPE_MAX_DEPTH, WIDTH);
    end
    if (DEPTH == 0) begin : g_bypass
        // clock and reset are deliberately unused in the bypass
        logic w_unused;
        assign w_unused = &{1'b0, CLK, RST_N};
        assign out = in;
    end else begin : g_pipe
        logic [WIDTH-1:0] w_stage [0:DEPTH];
        assign w_stage[0] = in;
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            pipeline_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .i_clk   (CLK),
                .i_rst_n (RST_N),
                .i_d     (w_stage[k]),
                .o_q     (w_stage[k+1])
            );
        end
        assign out = w_stage[DEPTH];
    end
endmodule

// File: tb/tb_pipeline_reg.sv
// tb_pipeline_reg: several pipeline_reg configurations checked against an input-history model.
module tb_pipeline_reg;
    localparam logic [31:0] RV = 32'hDEAD_BEEF;

    logic        CLK;
    logic        RST_N = 1'b0;
    logic [31:0] din;
    logic [31:0] o0, o1, o2, o3, o5, orv;
    logic        ow1;
    int          vectors = 0;
    int          miscompares = 0;

    pipeline_reg #(0)                          u_d0 (.CLK(CLK), .RST_N(RST_N), .in(din), .out(o0));
    pipeline_reg #(1)                          u_d1 (.CLK(CLK), .RST_N(RST_N), .in(din), .out(o1));
    pipeline_reg #(.DEPTH(2))                  u_d2 (.CLK(CLK), .RST_N(RST_N), .in(din), .out(o2));
    pipeline_reg #(.DEPTH(3))                  u_d3 (.CLK(CLK), .RST_N(RST_N), .in(din), .out(o3));
    pipeline_reg #(.DEPTH(5))                  u_d5 (.CLK(CLK), .RST_N(RST_N), .in(din), .out(o5));
    pipeline_reg #(.DEPTH(2), .RESET_VAL(RV))  u_rv (.CLK(CLK), .RST_N(RST_N), .in(din), .out(orv));
    pipeline_reg #(.DEPTH(1), .WIDTH(1))       u_w1 (.CLK(CLK), .RST_N(RST_N), .in(din[0]), .out(ow1));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: words accepted since the last reset, newest last; a depth-d output
    // shows the word accepted d edges ago, or the reset value if none exists yet.
    logic [31:0] hist[$];

    function automatic logic [31:0] expv(input int d, input logic [31:0] rv);
        if (d == 0) return din;
        return (hist.size() >= d) ? hist[hist.size()-d] : rv;
    endfunction

    always @(negedge RST_N) hist.delete();

    always @(posedge CLK) begin
        logic [31:0] e1;
        if (RST_N) begin
            hist.push_back(din);
            if (hist.size() > 8) void'(hist.pop_front());
        end
        #2;
        e1 = expv(1, 32'h0);
        chk("model_d0", o0, expv(0, 32'h0));
        chk("model_d1", o1, e1);
        chk("model_d2", o2, expv(2, 32'h0));
        chk("model_d3", o3, expv(3, 32'h0));
        chk("model_d5", o5, expv(5, 32'h0));
        chk("model_rv", orv, expv(2, RV));
        chk("model_w1", {31'b0, ow1}, {31'b0, e1[0]});
    end

    initial begin
        logic [31:0] vals[4] = '{32'd15, 32'd20, 32'd25, 32'd0};
        logic [31:0] l1[6] = '{32'd15, 32'd20, 32'd25, 32'd0, 32'd0, 32'd0};
        logic [31:0] l2[6] = '{32'd0, 32'd15, 32'd20, 32'd25, 32'd0, 32'd0};
        logic [31:0] l3[6] = '{32'd0, 32'd0, 32'd15, 32'd20, 32'd25, 32'd0};
        logic [31:0] lm[6] = '{32'd0, 32'd0, 32'd7, 32'd8, 32'd9, 32'd0};
        logic [31:0] mv[6] = '{32'd7, 32'd8, 32'd9, 32'd0, 32'd0, 32'd0};
        logic        tog[3] = '{1'b1, 1'b0, 1'b1};
        din = 32'hFFFF_FFFF;
        repeat (3) begin
            @(posedge CLK); #2;
            chk("rst_hold_d1", o1, 32'h0);
            chk("rst_hold_d2", o2, 32'h0);
            chk("rst_hold_d3", o3, 32'h0);
            chk("rst_hold_rv", orv, RV);
            chk("rst_hold_d0", o0, 32'hFFFF_FFFF);
        end
        @(negedge CLK);
        for (int i = 0; i < 6; i++) begin
            din = (i < 4) ? vals[i] : 32'h0;
            RST_N = 1'b1;
            @(posedge CLK); #2;
            chk("lat_d1", o1, l1[i]);
            chk("lat_d2", o2, l2[i]);
            chk("lat_d3", o3, l3[i]);
            @(negedge CLK);
        end
        for (int i = 0; i < 3; i++) begin
            din = {31'b0, tog[i]};
            @(posedge CLK); #2;
            chk("w1_toggle", {31'b0, ow1}, {31'b0, tog[i]});
            @(negedge CLK);
        end
        repeat (1000) begin
            din = $urandom;
            @(negedge CLK);
        end
        @(posedge CLK); #3;
        RST_N = 1'b0;
        #1;
        chk("async_d1", o1, 32'h0);
        chk("async_d3", o3, 32'h0);
        chk("async_d5", o5, 32'h0);
        chk("async_rv", orv, RV);
        chk("async_d0", o0, din);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            din = v;
            if (v < 3) @(negedge CLK);
        end
        @(posedge CLK); #1;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_d3", o3, 32'h0);
        #2;
        RST_N = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 6; i++) begin
            din = mv[i];
            @(posedge CLK); #2;
            chk("mid_stream_d3", o3, lm[i]);
            @(negedge CLK);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
